// File: rtl/exu_pkg.sv
// Shared EXU types: the decoded micro-op bundle from the IDU and the issue FSM states.
// Used by exu_issue_q (optional bypass controlled by EXU_ISSUE_BYPASS_EN) and exu_issue_ram.
package exu_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] opj;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [3:0]  rd;
    logic        speculation;
    logic        ren;
    logic        wen;
    logic        jen;
    logic        ben;
    logic        system;
    logic        func3_z;
    logic        csr_wen;
    logic        ebreak;
    logic        ecall;
    logic        mret;
  } idu_uop_t;

  localparam int UOP_W = 211;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } issue_state_t;

  // A serializing uop blocks all later issue until the EXU reports its commit.
  function automatic logic is_serializing(input idu_uop_t uop, input logic ser_csr);
    return uop.ebreak | uop.ecall | uop.mret | (uop.csr_wen & ser_csr);
  endfunction

endpackage

// File: rtl/exu_issue_ram.sv
// Issue-queue storage: DEPTH x UOP_W payload array with async read, plus per-entry
// valid and speculation bits supporting bulk spec clear and spec-entry squash.
module exu_issue_ram
  import exu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [UOP_W-1:0] wdata,
  input  logic             wspec,
  input  logic             re,
  input  logic [PTR_W-1:0] raddr,
  input  logic             spec_clr,
  input  logic             squash,
  output logic [UOP_W-1:0] rdata,
  output logic             rspec,
  output logic             rvalid,
  output logic [DEPTH-1:0] valid_vec,
  output logic [DEPTH-1:0] spec_vec
);

  logic [UOP_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] spec_q;

  // NOTE: the payload array is deliberately not reset; the valid bits decide whether a read is meaningful.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: state updates use non-blocking assignments so later statements (write) override earlier ones (squash/clear) cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      spec_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash && spec_q[i]) begin
          valid_q[i] <= 1'b0;
          spec_q[i]  <= 1'b0;
        end
        if (spec_clr) spec_q[i] <= 1'b0;
      end
      if (re) valid_q[raddr] <= 1'b0;
      if (we) begin
        valid_q[waddr] <= 1'b1;
        spec_q[waddr]  <= wspec;
      end
    end
  end

  assign rdata     = mem[raddr];
  assign rspec     = spec_q[raddr];
  assign rvalid    = valid_q[raddr];
  assign valid_vec = valid_q;
  assign spec_vec  = spec_q;

endmodule

// File: rtl/exu_issue_q.sv
// In-order EXU issue queue with branch squash and system-instruction serialization.
// Define EXU_ISSUE_BYPASS_EN to let a uop pass straight through an empty queue.
module exu_issue_q
  import exu_pkg::*;
#(
  parameter int DEPTH         = 2,
  parameter bit SERIALIZE_CSR = 1'b1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [UOP_W-1:0] in_uop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [UOP_W-1:0] out_uop,
  input  logic             br_resolve,
  input  logic             br_mispredict,
  input  logic             sys_commit,
  output logic [CNT_W-1:0] q_count,
  output logic             drain
);

  issue_state_t     state, state_next;
  logic [PTR_W-1:0] rptr, wptr, rptr_next, wptr_next, wptr_base;
  logic [CNT_W-1:0] count, count_next, count_base, spec_cnt, nonspec_cnt;

  logic [UOP_W-1:0] rdata;
  logic             rspec, rvalid;
  logic [DEPTH-1:0] valid_vec, spec_vec;

  idu_uop_t in_u, in_eff, head_uop, issue_uop;
  logic     squash, confirm, in_fire, q_valid, issue_valid;
  logic     deq, deq_q, byp_fire, store;

  assign squash  = br_resolve && br_mispredict;
  assign confirm = br_resolve && !br_mispredict;
  assign in_u    = in_uop;

  assign in_ready = (count < CNT_W'(DEPTH));
  assign in_fire  = in_valid && in_ready;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    in_eff             = in_u;
    in_eff.speculation = in_u.speculation && !confirm;
    head_uop           = rdata;
    head_uop.speculation = rspec;
    if (!rvalid) head_uop = '0;
  end

  assign q_valid = (count != '0) && (state == RUN) && !(squash && rspec);

`ifdef EXU_ISSUE_BYPASS_EN
  logic byp;
  assign byp         = (count == '0) && (state == RUN) && in_valid;
  assign issue_valid = byp ? !(squash && in_u.speculation) : q_valid;
  assign issue_uop   = byp ? in_eff : head_uop;
  assign deq         = issue_valid && out_ready && !squash;
  assign byp_fire    = byp && deq;
`else
  assign issue_valid = q_valid;
  assign issue_uop   = head_uop;
  assign deq         = issue_valid && out_ready && !squash;
  assign byp_fire    = 1'b0;
`endif

  assign deq_q = deq && !byp_fire;
  assign store = in_fire && !(squash && in_u.speculation) && !byp_fire;

  // Spec entries sit contiguously at the tail, so survivors are simply the first count-spec_cnt.
  always_comb begin
    spec_cnt = '0;
    for (int i = 0; i < DEPTH; i++) spec_cnt = spec_cnt + CNT_W'(valid_vec[i] & spec_vec[i]);
  end

  assign nonspec_cnt = count - spec_cnt;
  assign wptr_base   = squash ? rptr + nonspec_cnt[PTR_W-1:0] : wptr;
  assign count_base  = squash ? nonspec_cnt : count;
  assign count_next  = count_base + CNT_W'(store) - CNT_W'(deq_q);
  assign rptr_next   = rptr + PTR_W'(deq_q);
  assign wptr_next   = wptr_base + PTR_W'(store);

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (deq && is_serializing(issue_uop, SERIALIZE_CSR)) state_next = DRAIN;
      DRAIN:   if (sys_commit) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      rptr  <= rptr_next;
      wptr  <= wptr_next;
      count <= count_next;
    end
  end

  exu_issue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (store),
    .waddr     (wptr_base),
    .wdata     (in_eff),
    .wspec     (in_eff.speculation),
    .re        (deq_q),
    .raddr     (rptr),
    .spec_clr  (confirm),
    .squash    (squash),
    .rdata     (rdata),
    .rspec     (rspec),
    .rvalid    (rvalid),
    .valid_vec (valid_vec),
    .spec_vec  (spec_vec)
  );

  assign out_valid = issue_valid;
  assign out_uop   = issue_uop;
  assign q_count   = count;
  assign drain     = (state == DRAIN);

endmodule

// File: tb/tb_exu_issue_q.sv
// Scoreboard bench for exu_issue_q: a DEPTH=2/SERIALIZE_CSR=1 instance is monitored against
// an expected-issue queue; a DEPTH=4/SERIALIZE_CSR=0 instance shares the inputs for side checks.
module tb_exu_issue_q;
  import exu_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic        spec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, br_resolve, br_mispredict, sys_commit;
  idu_uop_t   in_uop;
  logic       in_ready, out_valid, drain;
  idu_uop_t   out_uop;
  logic [1:0] q_count;
  logic       b_in_ready, b_out_valid, b_drain;
  idu_uop_t   b_out_uop;
  logic [2:0] b_q_count;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  exu_issue_q #(.DEPTH(2), .SERIALIZE_CSR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
    .out_valid(out_valid), .out_ready(out_ready), .out_uop(out_uop),
    .br_resolve(br_resolve), .br_mispredict(br_mispredict), .sys_commit(sys_commit),
    .q_count(q_count), .drain(drain)
  );

  exu_issue_q #(.DEPTH(4), .SERIALIZE_CSR(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_uop(in_uop),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_uop(b_out_uop),
    .br_resolve(br_resolve), .br_mispredict(br_mispredict), .sys_commit(sys_commit),
    .q_count(b_q_count), .drain(b_drain)
  );

  // Issue monitor: a handshake seen mid-cycle completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL issue_unexpected: got pc=%h, expected nothing", out_uop.pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_uop.pc !== e.pc || out_uop.speculation !== e.spec) begin
          failures++;
          $display("FAIL issue_order: got pc=%h spec=%b, expected pc=%h spec=%b",
                   out_uop.pc, out_uop.speculation, e.pc, e.spec);
        end
      end
    end
  end

  function automatic idu_uop_t mk(input logic [31:0] pc, input logic spec, input int kind);
    idu_uop_t u;
    u             = '0;
    u.pc          = pc;
    u.inst        = pc ^ 32'h0000_0013;
    u.op1         = pc + 32'd1;
    u.speculation = spec;
    case (kind)
      1: begin u.system = 1'b1; u.ecall = 1'b1; end
      2: begin u.system = 1'b1; u.csr_wen = 1'b1; end
      default: u.ren = 1'b1;
    endcase
    return u;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input logic [31:0] pc, input logic spec);
    exp_t e;
    e.pc = pc;
    e.spec = spec;
    sb.push_back(e);
  endtask

  task automatic push(input idu_uop_t u);
    in_valid = 1'b1;
    in_uop   = u;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL push_ready pc=%h: got %b, expected 1", u.pc, in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (out_valid !== 1'b0 || q_count !== 2'd0 || drain !== 1'b0 || out_uop !== idu_uop_t'(0)) begin
      failures++;
      $display("FAIL %s: got out_valid=%b q_count=%0d drain=%b out_uop_pc=%h, expected 0/0/0/0",
               name, out_valid, q_count, drain, out_uop.pc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_uop = '0;
    br_resolve = 1'b0; br_mispredict = 1'b0; sys_commit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    tick();
  endtask

  task automatic test_in_order();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_uop    = mk(32'h8000_0000, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency: out_valid got %b in enqueue cycle, expected 0", out_valid);
    end
    tick();
    in_valid = 1'b0;
    push(mk(32'h8000_0004, 1'b0, 0));
    expect_issue(32'h8000_0000, 1'b0);
    expect_issue(32'h8000_0004, 1'b0);
    checks++;
    if (q_count !== 2'd2 || in_ready !== 1'b0 || out_uop.pc !== 32'h8000_0000) begin
      failures++;
      $display("FAIL full: got q_count=%0d in_ready=%b head=%h, expected 2/0/80000000",
               q_count, in_ready, out_uop.pc);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (q_count !== 2'd1 || sb.size() != 1) begin
      failures++;
      $display("FAIL first_issue: got q_count=%0d pending=%0d, expected 1/1", q_count, sb.size());
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (q_count !== 2'd0 || sb.size() != 0) begin
      failures++;
      $display("FAIL second_issue: got q_count=%0d pending=%0d, expected 0/0", q_count, sb.size());
    end
  endtask

  task automatic test_mispredict();
    out_ready = 1'b0;
    push(mk(32'h100, 1'b0, 0));
    push(mk(32'h104, 1'b1, 0));
    expect_issue(32'h100, 1'b0);
    br_resolve = 1'b1; br_mispredict = 1'b1;
    in_valid = 1'b1; in_uop = mk(32'h108, 1'b1, 0);
    @(negedge clk);
    checks++;
    if (b_in_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL squash_ready: got b_in_ready=%b in_ready=%b out_valid=%b, expected 1/0/1",
               b_in_ready, in_ready, out_valid);
    end
    tick();
    br_resolve = 1'b0; br_mispredict = 1'b0; in_valid = 1'b0;
    checks++;
    if (q_count !== 2'd1 || b_q_count !== 3'd1) begin
      failures++;
      $display("FAIL squash_count: got q_count=%0d b_q_count=%0d, expected 1/1", q_count, b_q_count);
    end
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    checks++;
    if (q_count !== 2'd0 || b_q_count !== 3'd0 || sb.size() != 0) begin
      failures++;
      $display("FAIL squash_drain: got q_count=%0d b_q_count=%0d pending=%0d, expected 0/0/0",
               q_count, b_q_count, sb.size());
    end
    push(mk(32'h10C, 1'b1, 0));
    br_resolve = 1'b1; br_mispredict = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL squash_head_spec: out_valid got %b, expected 0", out_valid);
    end
    tick();
    br_resolve = 1'b0; br_mispredict = 1'b0;
    checks++;
    if (q_count !== 2'd0) begin
      failures++;
      $display("FAIL squash_head_count: got %0d, expected 0", q_count);
    end
  endtask

  task automatic test_correct_predict();
    out_ready = 1'b0;
    push(mk(32'h100, 1'b0, 0));
    push(mk(32'h104, 1'b1, 0));
    br_resolve = 1'b1; br_mispredict = 1'b0;
    tick();
    br_resolve = 1'b0;
    expect_issue(32'h100, 1'b0);
    expect_issue(32'h104, 1'b0);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    checks++;
    if (q_count !== 2'd0 || sb.size() != 0) begin
      failures++;
      $display("FAIL confirm_issue: got q_count=%0d pending=%0d, expected 0/0", q_count, sb.size());
    end
    br_resolve = 1'b1; br_mispredict = 1'b0;
    in_valid = 1'b1; in_uop = mk(32'h120, 1'b1, 0);
    tick();
    in_valid = 1'b0;
    br_mispredict = 1'b1;
    tick();
    br_resolve = 1'b0; br_mispredict = 1'b0;
    checks++;
    if (q_count !== 2'd1) begin
      failures++;
      $display("FAIL confirm_forced_nonspec: got q_count=%0d, expected 1", q_count);
    end
    expect_issue(32'h120, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_serialize();
    sys_commit = 1'b1;
    tick();
    sys_commit = 1'b0;
    checks++;
    if (drain !== 1'b0) begin
      failures++;
      $display("FAIL commit_in_run: drain got %b, expected 0", drain);
    end
    out_ready = 1'b0;
    push(mk(32'h200, 1'b0, 1));
    push(mk(32'h204, 1'b0, 0));
    expect_issue(32'h200, 1'b0);
    expect_issue(32'h204, 1'b0);
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (drain !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL drain_hold cyc%0d: got drain=%b out_valid=%b, expected 1/0", i, drain, out_valid);
      end
      tick();
    end
    sys_commit = 1'b1;
    tick();
    sys_commit = 1'b0;
    checks++;
    if (drain !== 1'b0 || out_valid !== 1'b1 || out_uop.pc !== 32'h204) begin
      failures++;
      $display("FAIL resume: got drain=%b out_valid=%b pc=%h, expected 0/1/204", drain, out_valid, out_uop.pc);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (q_count !== 2'd0 || sb.size() != 0) begin
      failures++;
      $display("FAIL resume_done: got q_count=%0d pending=%0d, expected 0/0", q_count, sb.size());
    end
  endtask

  task automatic test_csr_serialize();
    out_ready = 1'b0;
    push(mk(32'h300, 1'b0, 2));
    push(mk(32'h304, 1'b0, 0));
    expect_issue(32'h300, 1'b0);
    expect_issue(32'h304, 1'b0);
    out_ready = 1'b1;
    tick();
    checks++;
    if (drain !== 1'b1 || b_drain !== 1'b0 || q_count !== 2'd1 || b_q_count !== 3'd1) begin
      failures++;
      $display("FAIL csr_drain: got drain=%b b_drain=%b q=%0d bq=%0d, expected 1/0/1/1",
               drain, b_drain, q_count, b_q_count);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || q_count !== 2'd1 || b_q_count !== 3'd0) begin
      failures++;
      $display("FAIL csr_hold: got out_valid=%b q=%0d bq=%0d, expected 0/1/0", out_valid, q_count, b_q_count);
    end
    sys_commit = 1'b1;
    tick();
    sys_commit = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++;
    if (q_count !== 2'd0 || drain !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL csr_resume: got q=%0d drain=%b pending=%0d, expected 0/0/0", q_count, drain, sb.size());
    end
  endtask

  task automatic test_reset_while_full();
    push(mk(32'h400, 1'b0, 1));
    expect_issue(32'h400, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    push(mk(32'h404, 1'b0, 0));
    push(mk(32'h408, 1'b0, 0));
    checks++;
    if (q_count !== 2'd2 || in_ready !== 1'b0 || drain !== 1'b1) begin
      failures++;
      $display("FAIL full_drain: got q=%0d in_ready=%b drain=%b, expected 2/0/1", q_count, in_ready, drain);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    checks++;
    if (b_q_count !== 3'd0 || b_drain !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_b: got bq=%0d b_drain=%b, expected 0/0", b_q_count, b_drain);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready: got %b, expected 1", in_ready);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_mispredict();
    test_correct_predict();
    test_serialize();
    test_csr_serialize();
    test_reset_while_full();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d pending, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
